// File: rtl/axil_pkg.sv
// Shared types and response codes for the two-master AXI-Lite arbiter.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      WR_RESP,
      RD_RESP,
      ERR_RESP,
      DRAIN
   } arb_state_t;

   typedef enum logic {
      OP_WR,
      OP_RD
   } op_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bus bundle; master modport drives requests, slave modport drives responses.
interface axil_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_rr_arb2.sv
// Two-requester round-robin grant; rr_last remembers the previous winner.
module axil_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update_en,
   output logic       gnt,
   output logic       gnt_valid
);
   logic rr_last_q, rr_last_d;

   always_comb begin
      gnt_valid = |req;
      gnt       = (&req) ? ~rr_last_q : req[1];
      rr_last_d = rr_last_q;
      if (update_en && gnt_valid) begin
         rr_last_d = gnt;
      end
   end

   // Reset to 1 so master 0 wins the first contested grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q <= 1'b1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
endmodule

// File: rtl/axil_arbiter_2to1.sv
// Shares one downstream AXI-Lite slave between two masters, one transaction at a time,
// with a response-phase watchdog that answers SLVERR upstream when the slave stalls.
module axil_arbiter_2to1
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic   clk,
   input  logic   rst,
   axil_if.slave  s0,
   axil_if.slave  s1,
   axil_if.master m,
   output logic   timeout_evt,
   output logic   busy
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t        state_q, state_d;
   op_t               op_q, op_d;
   logic              gnt_q, gnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              drain_done_q, drain_done_d;
   logic              timeout_evt_q, timeout_evt_d;

   logic [1:0] wreq, rreq;
   logic       arb_gnt, arb_valid;
   logic       sel_bready, sel_rready, m_bready, m_rready, resp_hs;

   assign wreq = {s1.awvalid & s1.wvalid, s0.awvalid & s0.wvalid};
   assign rreq = {s1.arvalid, s0.arvalid};

   axil_rr_arb2 u_rr (
      .clk       (clk),
      .rst       (rst),
      .req       (wreq | rreq),
      .update_en (state_q == IDLE),
      .gnt       (arb_gnt),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      sel_bready = gnt_q ? s1.bready : s0.bready;
      sel_rready = gnt_q ? s1.rready : s0.rready;
      // After a timeout the late downstream response is swallowed here.
      m_bready   = ((state_q == WR_RESP) && sel_bready) ||
                   (((state_q == ERR_RESP) || (state_q == DRAIN)) && (op_q == OP_WR));
      m_rready   = ((state_q == RD_RESP) && sel_rready) ||
                   (((state_q == ERR_RESP) || (state_q == DRAIN)) && (op_q == OP_RD));
      resp_hs    = (op_q == OP_WR) ? (m.bvalid & m_bready) : (m.rvalid & m_rready);
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      gnt_d         = gnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      awv_d         = awv_q;
      wv_d          = wv_q;
      arv_d         = arv_q;
      cnt_d         = cnt_q;
      drain_done_d  = drain_done_q;
      timeout_evt_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               gnt_d = arb_gnt;
               if (wreq[arb_gnt]) begin
                  op_d    = OP_WR;
                  addr_d  = arb_gnt ? s1.awaddr : s0.awaddr;
                  wdata_d = arb_gnt ? s1.wdata : s0.wdata;
                  wstrb_d = arb_gnt ? s1.wstrb : s0.wstrb;
                  awv_d   = 1'b1;
                  wv_d    = 1'b1;
                  state_d = WR_REQ;
               end else begin
                  op_d    = OP_RD;
                  addr_d  = arb_gnt ? s1.araddr : s0.araddr;
                  arv_d   = 1'b1;
                  state_d = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            awv_d = awv_q & ~m.awready;
            wv_d  = wv_q & ~m.wready;
            if (!awv_d && !wv_d) begin
               cnt_d   = '0;
               state_d = WR_RESP;
            end
         end
         RD_REQ: begin
            arv_d = arv_q & ~m.arready;
            if (!arv_d) begin
               cnt_d   = '0;
               state_d = RD_RESP;
            end
         end
         WR_RESP, RD_RESP: begin
            if (resp_hs) begin
               state_d = IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
               state_d       = ERR_RESP;
               timeout_evt_d = 1'b1;
               drain_done_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ERR_RESP: begin
            if (resp_hs) begin
               drain_done_d = 1'b1;
            end
            if ((op_q == OP_WR) ? sel_bready : sel_rready) begin
               state_d = (drain_done_q || resp_hs) ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (resp_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         op_q          <= OP_WR;
         gnt_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awv_q         <= 1'b0;
         wv_q          <= 1'b0;
         arv_q         <= 1'b0;
         cnt_q         <= '0;
         drain_done_q  <= 1'b0;
         timeout_evt_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         gnt_q         <= gnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awv_q         <= awv_d;
         wv_q          <= wv_d;
         arv_q         <= arv_d;
         cnt_q         <= cnt_d;
         drain_done_q  <= drain_done_d;
         timeout_evt_q <= timeout_evt_d;
      end
   end

   logic              up_awready, up_wready, up_arready, up_bvalid, up_rvalid;
   logic [1:0]        up_bresp, up_rresp;
   logic [DATA_W-1:0] up_rdata;

   always_comb begin
      up_awready = (state_q == WR_REQ) & awv_q & m.awready;
      up_wready  = (state_q == WR_REQ) & wv_q & m.wready;
      up_arready = (state_q == RD_REQ) & arv_q & m.arready;
      up_bvalid  = 1'b0;
      up_bresp   = RESP_OKAY;
      up_rvalid  = 1'b0;
      up_rresp   = RESP_OKAY;
      up_rdata   = '0;
      if (state_q == WR_RESP && m.bvalid) begin
         up_bvalid = 1'b1;
         up_bresp  = m.bresp;
      end
      if (state_q == RD_RESP && m.rvalid) begin
         up_rvalid = 1'b1;
         up_rresp  = m.rresp;
         up_rdata  = m.rdata;
      end
      if (state_q == ERR_RESP) begin
         up_bvalid = (op_q == OP_WR);
         up_bresp  = (op_q == OP_WR) ? RESP_SLVERR : RESP_OKAY;
         up_rvalid = (op_q == OP_RD);
         up_rresp  = (op_q == OP_RD) ? RESP_SLVERR : RESP_OKAY;
      end
   end

   always_comb begin
      s0.awready = up_awready & ~gnt_q;
      s0.wready  = up_wready & ~gnt_q;
      s0.arready = up_arready & ~gnt_q;
      s0.bvalid  = up_bvalid & ~gnt_q;
      s0.bresp   = gnt_q ? RESP_OKAY : up_bresp;
      s0.rvalid  = up_rvalid & ~gnt_q;
      s0.rresp   = gnt_q ? RESP_OKAY : up_rresp;
      s0.rdata   = gnt_q ? '0 : up_rdata;
      s1.awready = up_awready & gnt_q;
      s1.wready  = up_wready & gnt_q;
      s1.arready = up_arready & gnt_q;
      s1.bvalid  = up_bvalid & gnt_q;
      s1.bresp   = gnt_q ? up_bresp : RESP_OKAY;
      s1.rvalid  = up_rvalid & gnt_q;
      s1.rresp   = gnt_q ? up_rresp : RESP_OKAY;
      s1.rdata   = gnt_q ? up_rdata : '0;
      m.awaddr   = addr_q;
      m.awvalid  = awv_q;
      m.wdata    = wdata_q;
      m.wstrb    = wstrb_q;
      m.wvalid   = wv_q;
      m.bready   = m_bready;
      m.araddr   = addr_q;
      m.arvalid  = arv_q;
      m.rready   = m_rready;
   end

   assign timeout_evt = timeout_evt_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: doc/axil_arbiter_2to1.md
Name: axil_arbiter_2to1

Overview:
- Shares one downstream AXI-Lite slave port (m_*) between two upstream AXI-Lite masters (s0_*, s1_*), e.g. host CSR bridge and debug/DMA config master into the NPU register file.
- Allows one transaction in flight (write or read), with round-robin arbitration between masters.
- A response-phase watchdog returns SLVERR upstream if the slave stalls.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 1024, response-phase watchdog limit; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s{0,1}_awaddr / s{0,1}_awvalid  in  ADDR_W / 1  upstream write address
- s{0,1}_awready  out  1
- s{0,1}_wdata / s{0,1}_wstrb / s{0,1}_wvalid  in  DATA_W / DATA_W/8 / 1  upstream write data
- s{0,1}_wready  out  1
- s{0,1}_bresp / s{0,1}_bvalid  out  2 / 1  upstream write response
- s{0,1}_bready  in  1
- s{0,1}_araddr / s{0,1}_arvalid  in  ADDR_W / 1  upstream read address
- s{0,1}_arready  out  1
- s{0,1}_rdata / s{0,1}_rresp / s{0,1}_rvalid  out  DATA_W / 2 / 1  upstream read data
- s{0,1}_rready  in  1
- m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready  out  per AXI-Lite  downstream master side
- m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid  in  per AXI-Lite
- timeout_evt  out  1  one-cycle pulse when the watchdog fires
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge), including mid-transaction:
  - state = IDLE, rr_last = 1 (so s0 wins first), counter = 0.
  - All valid/ready outputs, timeout_evt and busy are 0; data/resp outputs are 0.
- Request per master: wreq = awvalid & wvalid; rreq = arvalid; req = wreq | rreq.
- Arbitration, IDLE only:
  - If both masters request, grant the master != rr_last; otherwise grant the sole requester.
  - Within the granted master, write beats read.
  - Grant, op and addr/data/strb are registered; rr_last is updated; next state is WR_REQ or RD_REQ. No upstream ready is asserted in the arbitration cycle.
- WR_REQ:
  - m_awvalid and m_wvalid are driven from registers and each drops independently after its handshake.
  - The upstream awready/wready for the granted master pulse exactly once, in the cycle the captured beat is accepted downstream (captured beat = upstream beat; upstream holds stable until its ready).
  - When both AW and W are done, go to WR_RESP.
- RD_REQ: same pattern with AR; when done, go to RD_RESP.
- WR_RESP / RD_RESP:
  - m_bready/m_rready = granted s_bready/s_rready; the response is forwarded combinationally to the granted master only.
  - The non-granted master sees bvalid/rvalid = 0.
  - On downstream handshake, return to IDLE. There is one idle cycle between transactions.
- Watchdog:
  - The counter increments every cycle in *_RESP and clears on entry.
  - When count == TIMEOUT_CYCLES-1 with no handshake, go to ERR_RESP and pulse timeout_evt.
- ERR_RESP:
  - Present bresp/rresp = 2'b10 (SLVERR), rdata = 0, valid to the granted master until it accepts.
  - Then go to DRAIN with m_bready/m_rready = 1 until the late downstream response arrives (discarded), then IDLE.
  - A downstream response arriving while still in ERR_RESP is absorbed and marks drain complete.
- Watchdog covers *_RESP only; the request phases never time out (AXI forbids dropping valid).
- Simultaneous wreq and rreq on the same master: the write goes first, and the read wins the next arbitration only if the other master is idle or it is this master's round-robin turn.

Decomposition:
- axil_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - typedef enum arb_state_t {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP, ERR_RESP, DRAIN}
  - typedef op_t {OP_WR, OP_RD}
- One sub-module, axil_rr_arb2: 2-requester round-robin grant with rr_last register and an update-enable input.

Test Plan:
- s0 writes 0x0000_0010 = 0xCAFE_F00D, wstrb=0xF; slave gives OKAY after 3 cycles -> m_awaddr=0x10, m_wdata=0xCAFEF00D; s0_bvalid with bresp=00; s1 sees no activity.
- s0 and s1 both assert arvalid in the same cycle after reset (s0 to 0x4, s1 to 0x8) -> s0 is served first, then s1; a repeated simultaneous request after both finish serves s0 again (alternation).
- s0 asserts a write and a read simultaneously with s1 idle -> the write completes (bvalid) before m_arvalid is asserted.
- TIMEOUT_CYCLES=8, slave never asserts rvalid -> after 8 cycles in RD_RESP, timeout_evt pulses, s0_rresp=2'b10, rdata=0. A late m_rvalid at cycle 20 is absorbed; the next s1 read is not corrupted.
- Slave accepts W two cycles before AW -> s0_wready and s0_awready each pulse once, in separate cycles; m_wvalid drops after the W handshake.
- rst asserted during WR_RESP -> next cycle all outputs are 0 and busy=0; a new s1 write then completes normally.
